fetch_sequencer: RTL and testbench

//   Run-control sequencer for the 5-stage MIPS pipeline. Drives the PC write enable and the
//   IF/ID write/flush of the fetch stage, plus a global enable for the downstream stages.

---
 rtl/fetch_sequencer.sv | 120 ++++++++++++
 tb/tb_fetch_sequencer.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Run-control sequencer for the 5-stage MIPS fetch stage: start/step control, stall, flush, HALT drain.
// Optional breakpoint support is compiled in with `define BREAKPOINT_EN.
module fetch_sequencer #(
  parameter int          DRAIN_CYCLES = 4,
  parameter int          CNT_W        = 32,
  parameter logic [31:0] HALT_WORD    = 32'hFFFFFFFF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic             i_step_mode,
  input  logic             i_step,
  input  logic [31:0]      i_instruction,
  input  logic             i_load_use_hazard,
  input  logic             i_taken,
`ifdef BREAKPOINT_EN
  input  logic [31:0]      i_pc,
  input  logic [31:0]      i_bp_addr,
  input  logic             i_bp_valid,
`endif
  output logic             o_pc_write,
  output logic             o_ifid_write,
  output logic             o_ifid_flush,
  output logic             o_pipe_enable,
  output logic             o_busy,
  output logic             o_halted,
  output logic [CNT_W-1:0] o_cycle_count
);

  localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  typedef enum logic [2:0] {
    IDLE, RUN, STEP_WAIT, STEP_EXEC, DRAIN, HALTED
  } state_t;

  state_t             state_reg, state_next;
  logic [DRAIN_W-1:0] drain_reg, drain_next;
  logic [CNT_W-1:0]   count_reg;
  logic               is_halt;
  logic               bp_hit;

  assign is_halt = (i_instruction == HALT_WORD);

`ifdef BREAKPOINT_EN
  // A taken branch or a stall owns the cycle, so the breakpoint only fires on a clean fetch.
  assign bp_hit = (state_reg == RUN) && i_bp_valid && (i_pc == i_bp_addr)
                  && !i_taken && !i_load_use_hazard;
`else
  assign bp_hit = 1'b0;
`endif

  always_comb begin
    state_next    = state_reg;
    drain_next    = drain_reg;
    o_pc_write    = 1'b0;
    o_ifid_write  = 1'b0;
    o_ifid_flush  = 1'b0;
    o_pipe_enable = 1'b0;
    o_halted      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (i_start) state_next = i_step_mode ? STEP_WAIT : RUN;
      end
      RUN, STEP_EXEC: begin
        if (state_reg == STEP_EXEC) state_next = STEP_WAIT;
        if (bp_hit) begin
          state_next = STEP_WAIT;
        end else begin
          o_pipe_enable = 1'b1;
          if (i_taken) begin
            // Flush wins over stall and over a wrong-path HALT word.
            o_pc_write   = 1'b1;
            o_ifid_write = 1'b1;
            o_ifid_flush = 1'b1;
          end else if (i_load_use_hazard) begin
            // Freeze PC and IF/ID; downstream keeps moving to insert the bubble.
          end else if (is_halt) begin
            o_ifid_flush = 1'b1;
            state_next   = DRAIN;
            drain_next   = DRAIN_W'(DRAIN_CYCLES - 1);
          end else begin
            o_pc_write   = 1'b1;
            o_ifid_write = 1'b1;
          end
        end
      end
      STEP_WAIT: begin
        if (i_step) state_next = STEP_EXEC;
      end
      DRAIN: begin
        o_ifid_flush  = 1'b1;
        o_pipe_enable = 1'b1;
        if (drain_reg == '0) state_next = HALTED;
        else                 drain_next = drain_reg - DRAIN_W'(1);
      end
      HALTED: begin
        o_halted = 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  assign o_busy        = (state_reg != IDLE) && (state_reg != HALTED);
  assign o_cycle_count = count_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      drain_reg <= '0;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      drain_reg <= drain_next;
      // Saturate instead of wrapping so a long run never reports a small count.
      if (o_pipe_enable && (count_reg != {CNT_W{1'b1}}))
        count_reg <= count_reg + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: expected control vectors are queued per cycle and checked
// against the DUT just before the next rising edge; the cycle counter is tracked by a saturating model.
module tb_fetch_sequencer;
  localparam int CNT_W = 5;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [31:0] HALT = 32'hFFFFFFFF;
  localparam logic [31:0] NOP  = 32'h00000000;

  // Control vector layout: {pc_write, ifid_write, ifid_flush, pipe_enable, busy, halted}
  localparam logic [5:0] E_OFF  = 6'b000000;
  localparam logic [5:0] E_WAIT = 6'b000010;
  localparam logic [5:0] E_RUN  = 6'b110110;
  localparam logic [5:0] E_STL  = 6'b000110;
  localparam logic [5:0] E_TKN  = 6'b111110;
  localparam logic [5:0] E_FLS  = 6'b001110;
  localparam logic [5:0] E_HLT  = 6'b000001;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic i_start = 0, i_step_mode = 0, i_step = 0, i_load_use_hazard = 0, i_taken = 0;
  logic [31:0] i_instruction = NOP;
  logic o_pc_write, o_ifid_write, o_ifid_flush, o_pipe_enable, o_busy, o_halted;
  logic [CNT_W-1:0] o_cycle_count;
`ifdef BREAKPOINT_EN
  logic [31:0] i_pc = 32'h0;
  logic [31:0] i_bp_addr = 32'h0;
  logic        i_bp_valid = 1'b0;
`endif

  typedef struct {
    logic [5:0]       ctl;
    logic [CNT_W-1:0] cnt;
    string            tag;
  } exp_t;

  exp_t sb[$];
  int tests = 0;
  int fails = 0;
  logic [CNT_W-1:0] exp_count = '0;
  logic [5:0] obs;

  assign obs = {o_pc_write, o_ifid_write, o_ifid_flush, o_pipe_enable, o_busy, o_halted};

  always #5 clk = ~clk;

  fetch_sequencer #(.DRAIN_CYCLES(4), .CNT_W(CNT_W), .HALT_WORD(HALT)) dut (
    .clk(clk), .rst(rst),
    .i_start(i_start), .i_step_mode(i_step_mode), .i_step(i_step),
    .i_instruction(i_instruction), .i_load_use_hazard(i_load_use_hazard), .i_taken(i_taken),
`ifdef BREAKPOINT_EN
    .i_pc(i_pc), .i_bp_addr(i_bp_addr), .i_bp_valid(i_bp_valid),
`endif
    .o_pc_write(o_pc_write), .o_ifid_write(o_ifid_write), .o_ifid_flush(o_ifid_flush),
    .o_pipe_enable(o_pipe_enable), .o_busy(o_busy), .o_halted(o_halted),
    .o_cycle_count(o_cycle_count)
  );

  task automatic chk(input logic [5:0] e, input logic [CNT_W-1:0] c, input string tag);
    tests++;
    assert (obs === e) else begin
      fails++;
      $error("FAIL %s ctl observed=%b expected=%b", tag, obs, e);
    end
    tests++;
    assert (o_cycle_count === c) else begin
      fails++;
      $error("FAIL %s count observed=%0d expected=%0d", tag, o_cycle_count, c);
    end
    $display("[TB] %s ctl=%b count=%0d", tag, obs, o_cycle_count);
  endtask

  // One clock cycle: drive inputs after the falling edge, check just before the rising edge.
  task automatic cyc(input logic s, m, st, haz, tk, input logic [31:0] ins,
                     input logic [5:0] e, input string tag);
    exp_t x;
    @(negedge clk);
    i_start = s; i_step_mode = m; i_step = st;
    i_load_use_hazard = haz; i_taken = tk; i_instruction = ins;
    x.ctl = e; x.cnt = exp_count; x.tag = tag;
    sb.push_back(x);
    #2;
    x = sb.pop_front();
    chk(x.ctl, x.cnt, x.tag);
    if (e[2] && exp_count != CNT_MAX) exp_count = exp_count + 1'b1;
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst = 1'b1;
    i_start = 1'b1; i_step = 1'b1;
    #1;
    chk(E_OFF, '0, tag);
    @(negedge clk);
    rst = 1'b0;
    i_start = 1'b0; i_step = 1'b0;
    exp_count = '0;
    sb.delete();
  endtask

  initial begin
    // Outputs stay low while reset is held, even with start/step requested.
    i_start = 1'b1; i_step = 1'b1;
    #12;
    chk(E_OFF, '0, "reset_hold");
    @(negedge clk);
    rst = 1'b0;
    i_start = 1'b0; i_step = 1'b0;

    // Continuous run with NOPs; start and step together: start wins.
    cyc(1, 0, 1, 0, 0, NOP, E_OFF, "idle_start");
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0, NOP, E_RUN, "run_nop");
    cyc(0, 0, 0, 1, 0, NOP,  E_STL, "run_hazard");
    cyc(0, 0, 0, 1, 1, NOP,  E_TKN, "run_taken_hazard");
    cyc(0, 0, 0, 0, 1, HALT, E_TKN, "run_taken_halt");
    cyc(0, 0, 0, 1, 0, HALT, E_STL, "run_hazard_halt");
    cyc(0, 0, 1, 0, 0, NOP,  E_RUN, "run_step_ignored");

    // HALT: flush cycle, four drain cycles (taken/hazard ignored), then parked.
    cyc(0, 0, 0, 0, 0, HALT, E_FLS, "halt_fetch");
    cyc(0, 0, 0, 0, 1, NOP,  E_FLS, "drain_taken");
    cyc(0, 0, 0, 1, 0, NOP,  E_FLS, "drain_hazard");
    cyc(0, 0, 0, 0, 0, NOP,  E_FLS, "drain");
    cyc(0, 0, 0, 0, 0, NOP,  E_FLS, "drain_last");
    cyc(1, 0, 0, 0, 0, NOP,  E_HLT, "halted_start");
    cyc(0, 1, 1, 0, 0, NOP,  E_HLT, "halted_step");
    cyc(1, 1, 0, 0, 0, NOP,  E_HLT, "halted_frozen");

    // Single-step: three steps five cycles apart, the middle one stalled.
    do_reset("reset_step");
    cyc(1, 1, 0, 0, 0, NOP, E_OFF,  "idle_start_step");
    cyc(0, 0, 0, 0, 0, NOP, E_WAIT, "step_wait");
    for (int k = 0; k < 3; k++) begin
      cyc(0, 0, 1, 0, 0, NOP, E_WAIT, "step_req");
      cyc(0, 0, 0, (k == 1), 0, NOP, (k == 1) ? E_STL : E_RUN, "step_exec");
      for (int j = 0; j < 3; j++) cyc(1, 0, 0, 0, 0, NOP, E_WAIT, "step_idle");
    end
    // HALT reached by a step; drain runs free, then async reset mid-drain.
    cyc(0, 0, 1, 0, 0, NOP,  E_WAIT, "step_req_halt");
    cyc(0, 0, 0, 0, 0, HALT, E_FLS,  "step_halt");
    cyc(0, 0, 0, 0, 0, NOP,  E_FLS,  "step_drain");
    do_reset("reset_in_drain");

    // Clean restart after reset, then run long enough to saturate the counter.
    cyc(1, 0, 0, 0, 0, NOP, E_OFF, "restart");
    for (int i = 0; i < 35; i++) cyc(0, 0, 0, 0, 0, NOP, E_RUN, "run_sat");

`ifdef BREAKPOINT_EN
    do_reset("reset_bp");
    i_bp_addr = 32'h10; i_bp_valid = 1'b1; i_pc = 32'h08;
    cyc(1, 0, 0, 0, 0, NOP, E_OFF, "bp_start");
    cyc(0, 0, 0, 0, 0, NOP, E_RUN, "bp_run_08");
    i_pc = 32'h0C;
    cyc(0, 0, 0, 0, 0, NOP, E_RUN, "bp_run_0c");
    i_pc = 32'h10;
    cyc(0, 0, 0, 0, 0, NOP, E_WAIT, "bp_hit");
    cyc(0, 0, 0, 0, 0, NOP, E_WAIT, "bp_wait");
    cyc(0, 0, 1, 0, 0, NOP, E_WAIT, "bp_step_req");
    cyc(0, 0, 0, 0, 0, NOP, E_RUN,  "bp_step_exec");
    i_pc = 32'h14;
    cyc(0, 0, 0, 0, 0, NOP, E_WAIT, "bp_stop_14");
    i_bp_valid = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
